// File: rtl/axis_rti_reader.sv
// Streams a completed RTI line-buffer bank out as AXI-Stream, one {down, up} beat per range bin.
// Define AXIS_RTI_READER_PEAK_EN to add the per-line peak tracker outputs (peak_mag/peak_bin/peak_valid).
//
// state   | meaning
// S_IDLE  | no line active; waiting for line_ready or a pending request
// S_READ  | issuing RAM reads for bins 0..N-1
// S_DRAIN | all reads issued; waiting for the tlast beat to be accepted
module axis_rti_reader #(
  parameter int MAG_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 12,
  parameter int TUSER_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [3:0]             cfg_bins,
  input  logic                   line_ready,
  input  logic                   line_bank,
  output logic                   line_busy,
  output logic                   ram_en,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  input  logic [2*MAG_WIDTH-1:0] ram_rdata,
  output logic [2*MAG_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   overrun
`ifdef AXIS_RTI_READER_PEAK_EN
  ,
  output logic [MAG_WIDTH-1:0]   peak_mag,
  output logic [ADDR_WIDTH-2:0]  peak_bin,
  output logic                   peak_valid
`endif
);

  localparam int BW = ADDR_WIDTH - 1;
  localparam int DW = 2 * MAG_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic                   bank_q, bank_d;
  logic [BW-1:0]          bin_q, bin_d;
  logic [BW-1:0]          n_last_q, n_last_d;
  logic                   pend_q, pend_d;
  logic                   pend_bank_q, pend_bank_d;
  logic [TUSER_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic                   overrun_q, overrun_d;
  logic                   infl_q, infl_d;
  logic                   infl_last_q, infl_last_d;

  logic [DW-1:0]          fifo_data_q [2];
  logic [1:0]             fifo_last_q;
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             occ_q, occ_d;

  logic [3:0]             bins_clamped;
  logic [BW-1:0]          n_last_calc;
  logic                   pop, last_hs, issue_ok, bin_is_last, start_bank;
  logic [1:0]             budget;

  always_comb begin
    bins_clamped = cfg_bins;
    if (int'(cfg_bins) > BW) bins_clamped = 4'(BW);
    n_last_calc = {BW{1'b1}} >> (BW - int'(bins_clamped));
  end

  assign m_axis_tvalid = (occ_q != 2'd0);
  assign m_axis_tdata  = fifo_data_q[rd_ptr_q];
  assign m_axis_tlast  = m_axis_tvalid && fifo_last_q[rd_ptr_q];
  assign m_axis_tuser  = line_cnt_q;
  assign overrun       = overrun_q;
  assign line_busy     = (state_q != S_IDLE);
  assign ram_addr      = {bank_q, bin_q};

  assign pop         = m_axis_tvalid && m_axis_tready;
  assign last_hs     = pop && m_axis_tlast;
  assign bin_is_last = (bin_q == n_last_q);
  assign start_bank  = line_ready ? line_bank : pend_bank_q;

  // Slots committed for next cycle: a read may issue only if its data is
  // guaranteed a FIFO entry whatever tready does afterwards.
  assign budget   = occ_q - {1'b0, pop} + {1'b0, infl_q};
  assign issue_ok = (budget < 2'd2);
  assign occ_d    = occ_q + {1'b0, infl_q} - {1'b0, pop};

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    bin_d       = bin_q;
    n_last_d    = n_last_q;
    pend_d      = pend_q;
    pend_bank_d = pend_bank_q;
    line_cnt_d  = line_cnt_q;
    overrun_d   = overrun_q;
    ram_en      = 1'b0;

    if (state_q != S_IDLE && line_ready) begin
      if (pend_q) overrun_d = 1'b1;
      pend_d      = 1'b1;
      pend_bank_d = line_bank;
    end

    case (state_q)
      S_IDLE: begin
        if (line_ready || pend_q) begin
          state_d  = S_READ;
          bank_d   = start_bank;
          n_last_d = n_last_calc;
          bin_d    = '0;
          pend_d   = 1'b0;
        end
      end
      S_READ: begin
        if (issue_ok) begin
          ram_en = 1'b1;
          if (bin_is_last) state_d = S_DRAIN;
          else             bin_d   = bin_q + BW'(1);
        end
      end
      S_DRAIN: begin
        if (last_hs) begin
          line_cnt_d = line_cnt_q + TUSER_WIDTH'(1);
          // A request arriving on the completion cycle chains with no idle gap.
          if (line_ready || pend_q) begin
            state_d  = S_READ;
            bank_d   = start_bank;
            n_last_d = n_last_calc;
            bin_d    = '0;
            pend_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    infl_d      = ram_en;
    infl_last_d = ram_en && bin_is_last;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      bank_q      <= 1'b0;
      bin_q       <= '0;
      n_last_q    <= '0;
      pend_q      <= 1'b0;
      pend_bank_q <= 1'b0;
      line_cnt_q  <= '0;
      overrun_q   <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      bin_q       <= bin_d;
      n_last_q    <= n_last_d;
      pend_q      <= pend_d;
      pend_bank_q <= pend_bank_d;
      line_cnt_q  <= line_cnt_d;
      overrun_q   <= overrun_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      occ_q          <= 2'd0;
    end else begin
      if (infl_q) begin
        fifo_data_q[wr_ptr_q] <= ram_rdata;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end

`ifdef AXIS_RTI_READER_PEAK_EN
  logic [MAG_WIDTH-1:0] pk_max_q, peak_mag_q, up_mag, cur_max;
  logic [BW-1:0]        pk_bin_q, peak_bin_q, beat_q, cur_bin;
  logic                 peak_valid_q, take;

  // Strict compare so a tie keeps the earlier (lower) bin.
  always_comb begin
    up_mag  = m_axis_tdata[MAG_WIDTH-1:0];
    take    = (beat_q == '0) || (up_mag > pk_max_q);
    cur_max = take ? up_mag : pk_max_q;
    cur_bin = take ? beat_q : pk_bin_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pk_max_q     <= '0;
      pk_bin_q     <= '0;
      beat_q       <= '0;
      peak_mag_q   <= '0;
      peak_bin_q   <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_valid_q <= 1'b0;
      if (pop) begin
        if (m_axis_tlast) begin
          peak_mag_q   <= cur_max;
          peak_bin_q   <= cur_bin;
          peak_valid_q <= 1'b1;
          beat_q       <= '0;
        end else begin
          pk_max_q <= cur_max;
          pk_bin_q <= cur_bin;
          beat_q   <= beat_q + BW'(1);
        end
      end
    end
  end

  assign peak_mag   = peak_mag_q;
  assign peak_bin   = peak_bin_q;
  assign peak_valid = peak_valid_q;
`endif

endmodule

// File: tb/tb_axis_rti_reader.sv
// Scoreboard bench for axis_rti_reader: stimulus pushes expected beats, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_axis_rti_reader;
  localparam int MW = 16;
  localparam int AW = 12;
  localparam int TW = 16;
  localparam int DW = 2 * MW;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [3:0]    cfg_bins = 4'd0;
  logic          line_ready = 1'b0;
  logic          line_bank = 1'b0;
  logic          line_busy;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [TW-1:0] m_axis_tuser;
  logic          overrun;
`ifdef AXIS_RTI_READER_PEAK_EN
  logic [MW-1:0] peak_mag;
  logic [AW-2:0] peak_bin;
  logic          peak_valid;
`endif

  axis_rti_reader #(.MAG_WIDTH(MW), .ADDR_WIDTH(AW), .TUSER_WIDTH(TW)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_bins(cfg_bins),
    .line_ready(line_ready), .line_bank(line_bank), .line_busy(line_busy),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .overrun(overrun)
`ifdef AXIS_RTI_READER_PEAK_EN
    , .peak_mag(peak_mag), .peak_bin(peak_bin), .peak_valid(peak_valid)
`endif
  );

  always #5 aclk = ~aclk;

  logic [DW-1:0] mem [4096];
  always @(posedge aclk) if (ram_en) ram_rdata <= mem[ram_addr];

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [TW-1:0] user;
  } beat_t;
  beat_t exp_q[$];

  int n_checks = 0, n_fails = 0;
  int mon_checks = 0, mon_fails = 0;
  int hs_total = 0;
  int last_cyc = 0;

  function automatic logic [DW-1:0] word(input int bank, input int i);
    if (bank == 1) return 32'(i) * 32'h0001_0001;
    return 32'hB000_0000 + 32'(i) * 32'h0001_0001;
  endfunction

  // Monitor: every handshake pops one expected beat; a stalled beat must stay put.
  beat_t         mon_e;
  logic          stall_v = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;
  logic [TW-1:0] stall_user;
  always @(negedge aclk) begin
    if (!aresetn) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        mon_checks++;
        if (!(m_axis_tvalid && m_axis_tdata == stall_data && m_axis_tlast == stall_last &&
              m_axis_tuser == stall_user)) begin
          mon_fails++;
          $display("FAIL stall_hold: got v=%0b d=0x%0h l=%0b u=%0d, required v=1 d=0x%0h l=%0b u=%0d",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser,
                   stall_data, stall_last, stall_user);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        mon_checks++;
        if (exp_q.size() == 0) begin
          mon_fails++;
          $display("FAIL unexpected_beat: got d=0x%0h l=%0b u=%0d, required no beat",
                   m_axis_tdata, m_axis_tlast, m_axis_tuser);
        end else begin
          mon_e = exp_q.pop_front();
          if (m_axis_tdata !== mon_e.data || m_axis_tlast !== mon_e.last ||
              m_axis_tuser !== mon_e.user) begin
            mon_fails++;
            $display("FAIL beat: got d=0x%0h l=%0b u=%0d, required d=0x%0h l=%0b u=%0d",
                     m_axis_tdata, m_axis_tlast, m_axis_tuser, mon_e.data, mon_e.last, mon_e.user);
          end
        end
        hs_total++;
        if (m_axis_tlast) last_cyc = cyc;
      end
      stall_v    = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
      stall_last = m_axis_tlast;
      stall_user = m_axis_tuser;
    end
  end

`ifdef AXIS_RTI_READER_PEAK_EN
  int pk_pulses = 0, pk_cyc = 0;
  always @(negedge aclk) if (aresetn && peak_valid) begin
    pk_pulses++;
    pk_cyc = cyc;
  end
`endif

  // tready pattern: mode 0 = always high, mode 1 = 1,0,0,1 repeating.
  int rdy_mode = 0;
  initial begin
    int phase = 0;
    forever begin
      @(posedge aclk);
      #1;
      if (rdy_mode == 0) m_axis_tready = 1'b1;
      else m_axis_tready = (phase % 4 == 0) || (phase % 4 == 3);
      phase++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_line(input int bank, input int n, input int user);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = word(bank, i);
      b.last = (i == n - 1);
      b.user = TW'(user);
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse(input logic bank);
    @(posedge aclk); #1;
    line_ready = 1'b1;
    line_bank  = bank;
    @(posedge aclk); #1;
    line_ready = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge aclk); #1;
      if (exp_q.size() == 0 && !line_busy && !m_axis_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL %s_drain: got %0d beats outstanding busy=%0b, required 0 and 0",
               name, exp_q.size(), line_busy);
    end
  endtask

  initial begin
    int k, t_first, base;
    bit hit;
    for (int i = 0; i < 2048; i++) begin
      mem[i]        = word(0, i);
      mem[2048 + i] = word(1, i);
    end

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_busy", 64'(line_busy), 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_tuser_tdata", {16'd0, m_axis_tuser, m_axis_tdata}, 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Line A: bank 1, N=8, tready high; latency and back-to-back beats.
    cfg_bins = 4'd3;
    push_line(1, 8, 0);
    @(posedge aclk); #1;
    chk("busy_before_pulse", 64'(line_busy), 64'd0);
    line_ready = 1'b1;
    line_bank  = 1'b1;
    k = 0;
    t_first = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge aclk); #1;
      line_ready = 1'b0;
      k++;
      if (k == 1) chk("busy_after_pulse", 64'(line_busy), 64'd1);
      if (m_axis_tvalid) begin
        t_first = cyc;
        break;
      end
    end
    chk("first_tvalid_latency", 64'(k), 64'd3);
    wait_drain(100, "lineA");
    chk("lineA_consecutive", 64'(last_cyc - t_first), 64'd7);

    // Line B: same line under a 1,0,0,1 tready pattern.
    rdy_mode = 1;
    push_line(1, 8, 1);
    pulse(1'b1);
    wait_drain(200, "lineB");
    rdy_mode = 0;

    // Three requests within one N=16 line: bank 1 request is replaced by bank 0.
    chk("overrun_before", 64'(overrun), 64'd0);
    cfg_bins = 4'd4;
    push_line(0, 16, 2);
    push_line(0, 16, 3);
    pulse(1'b0);
    repeat (3) @(posedge aclk);
    pulse(1'b1);
    repeat (3) @(posedge aclk);
    pulse(1'b0);
    wait_drain(300, "overrun");
    chk("overrun_after", 64'(overrun), 64'd1);

    // Clamp: cfg_bins=15 reads the full 2048-bin bank; cfg_bins=0 is one beat.
    cfg_bins = 4'd15;
    push_line(0, 2048, 4);
    pulse(1'b0);
    wait_drain(5000, "clamp2048");
    cfg_bins = 4'd0;
    push_line(0, 1, 5);
    pulse(1'b0);
    wait_drain(50, "single");

    // Reset after beat 3 of 8 abandons the line; next line restarts at tuser 0.
    cfg_bins = 4'd3;
    base = hs_total;
    push_line(1, 8, 6);
    pulse(1'b1);
    hit = 1'b0;
    for (int j = 0; j < 50; j++) begin
      if (hs_total - base == 3) begin
        hit = 1'b1;
        break;
      end
      @(posedge aclk); #1;
    end
    chk("reached_beat3", 64'(hit), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_busy", 64'(line_busy), 64'd0);
    chk("midrst_overrun", 64'(overrun), 64'd0);
    exp_q.delete();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    push_line(1, 8, 0);
    pulse(1'b1);
    wait_drain(100, "after_reset");

`ifdef AXIS_RTI_READER_PEAK_EN
    begin
      beat_t b;
      int up_v[4] = '{5, 9, 2, 9};
      int p0;
      for (int i = 0; i < 4; i++) begin
        mem[2048 + i] = {16'(16'h0100 + i), 16'(up_v[i])};
        b.data = {16'(16'h0100 + i), 16'(up_v[i])};
        b.last = (i == 3);
        b.user = 16'd1;
        exp_q.push_back(b);
      end
      p0 = pk_pulses;
      cfg_bins = 4'd2;
      pulse(1'b1);
      wait_drain(100, "peak");
      repeat (3) @(posedge aclk);
      #1;
      chk("peak_pulses", 64'(pk_pulses - p0), 64'd1);
      chk("peak_mag", 64'(peak_mag), 64'd9);
      chk("peak_bin", 64'(peak_bin), 64'd1);
      chk("peak_timing", 64'(pk_cyc - last_cyc), 64'd1);
    end
`endif

    repeat (5) @(posedge aclk);
    #1;
    chk("queue_empty_end", 64'(exp_q.size()), 64'd0);
    chk("idle_end", 64'({line_busy, m_axis_tvalid}), 64'd0);

    n_checks += mon_checks;
    n_fails  += mon_fails;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
